// File: rtl/md_if.sv
// ============================================================================
// Module      : md_if
// Description : Issue/result bundle between the EX-stage issue logic and the
//               multiply/divide unit (md_unit).
//               master : issuing side (drives start/op/a/b/cancel)
//               slave  : md_unit side (drives busy/stall_req/hi/lo/div_zero)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface md_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             stall_req;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (
        output start, op, a, b, cancel,
        input  busy, stall_req, hi, lo, div_zero
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, stall_req, hi, lo, div_zero
    );
endinterface

`default_nettype wire

// File: rtl/md_unit.sv
// ============================================================================
// Module      : md_unit
// Description : Multi-cycle multiply/divide unit with HI/LO registers.
//               Results are computed at accept, held in pending registers and
//               committed to HI/LO after MULT_CYCLES / DIV_CYCLES busy cycles.
//               Optional macro MD_MADD_EN enables MADD/MADDU/MSUB/MSUBU (ops 6-9).
// Ports       : clk            rising-edge clock
//               reset          asynchronous active-low reset
//               bus (slave)    start/op/a/b/cancel in;
//                              busy/stall_req/hi/lo/div_zero out
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    md_if.slave  bus
);
    localparam int CYC_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CYC_MAX) + 1;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_MUL  = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0]    CNT_DIV  = CW'(DIV_CYCLES - 1);

    // State
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] pend_q, pend_d;
    logic               pend_div_q, pend_div_d;   // pending op is a divide
    logic               pend_dz_q, pend_dz_d;     // pending divide had b==0
    logic               busy_q, busy_d;
    logic               dz_q, dz_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    // Decode
    logic w_is_mul, w_is_div, w_is_mt, w_is_mac, w_multi, w_accept, w_signed;

    assign w_is_mul = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    assign w_is_div = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign w_is_mt  = (bus.op == OP_MTHI) || (bus.op == OP_MTLO);
`ifdef MD_MADD_EN
    assign w_is_mac = (bus.op >= OP_MADD) && (bus.op <= OP_MSUBU);
`else
    assign w_is_mac = 1'b0;
`endif
    assign w_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV) ||
                      (bus.op == OP_MADD) || (bus.op == OP_MSUB);
    assign w_multi  = w_is_mul || w_is_div || w_is_mac;
    // Reserved ops fail both w_multi and w_is_mt, so they are never accepted.
    assign w_accept = bus.start && !bus.cancel && !busy_q && (w_multi || w_is_mt);

    // Multiply: extend to 2*WIDTH so one multiplier serves signed and unsigned.
    logic [2*WIDTH-1:0] w_a_ext, w_b_ext, w_prod;
    assign w_a_ext = {{WIDTH{w_signed & bus.a[WIDTH-1]}}, bus.a};
    assign w_b_ext = {{WIDTH{w_signed & bus.b[WIDTH-1]}}, bus.b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Divide: unsigned core on magnitudes, signs re-applied afterwards.
    // The most-negative / -1 case falls out naturally: the magnitude quotient
    // 2^(WIDTH-1) re-reads as the most-negative value and the remainder is 0.
    logic             w_a_neg, w_b_neg, w_b_zero;
    logic [WIDTH-1:0] w_n, w_d, w_d_safe, w_uq, w_ur, w_q, w_r;
    assign w_a_neg  = w_signed & bus.a[WIDTH-1];
    assign w_b_neg  = w_signed & bus.b[WIDTH-1];
    assign w_b_zero = (bus.b == '0);
    assign w_n      = w_a_neg ? (~bus.a + ONE) : bus.a;
    assign w_d      = w_b_neg ? (~bus.b + ONE) : bus.b;
    assign w_d_safe = w_b_zero ? ONE : w_d;
    assign w_uq     = w_n / w_d_safe;
    assign w_ur     = w_n % w_d_safe;
    assign w_q      = (w_a_neg ^ w_b_neg) ? (~w_uq + ONE) : w_uq;
    assign w_r      = w_a_neg ? (~w_ur + ONE) : w_ur;

    // Result selection for the pending register
    logic [2*WIDTH-1:0] w_res;
`ifdef MD_MADD_EN
    logic [2*WIDTH-1:0] w_acc;
    logic               w_sub;
    assign w_sub = (bus.op == OP_MSUB) || (bus.op == OP_MSUBU);
    assign w_acc = w_sub ? ({hi_q, lo_q} - w_prod) : ({hi_q, lo_q} + w_prod);
`endif

    always_comb begin
        w_res = w_prod;
        if (w_is_div) begin
            w_res = w_b_zero ? {bus.a, ALL_ONES} : {w_r, w_q};
        end
`ifdef MD_MADD_EN
        if (w_is_mac) begin
            w_res = w_acc;
        end
`endif
    end

    // Next state
    always_comb begin
        hi_d       = hi_q;
        lo_d       = lo_q;
        pend_d     = pend_q;
        pend_div_d = pend_div_q;
        pend_dz_d  = pend_dz_q;
        busy_d     = busy_q;
        dz_d       = dz_q;
        cnt_d      = cnt_q;
        if (busy_q) begin
            if (cnt_q == '0) begin
                hi_d   = pend_q[2*WIDTH-1:WIDTH];
                lo_d   = pend_q[WIDTH-1:0];
                busy_d = 1'b0;
                if (pend_div_q) begin
                    dz_d = pend_dz_q;
                end
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end else if (w_accept) begin
            if (bus.op == OP_MTHI) begin
                hi_d = bus.a;
            end else if (bus.op == OP_MTLO) begin
                lo_d = bus.a;
            end else begin
                pend_d     = w_res;
                pend_div_d = w_is_div;
                pend_dz_d  = w_is_div & w_b_zero;
                busy_d     = 1'b1;
                cnt_d      = w_is_div ? CNT_DIV : CNT_MUL;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q       <= '0;
            lo_q       <= '0;
            pend_q     <= '0;
            pend_div_q <= 1'b0;
            pend_dz_q  <= 1'b0;
            busy_q     <= 1'b0;
            dz_q       <= 1'b0;
            cnt_q      <= '0;
        end else begin
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            pend_q     <= pend_d;
            pend_div_q <= pend_div_d;
            pend_dz_q  <= pend_dz_d;
            busy_q     <= busy_d;
            dz_q       <= dz_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.stall_req = busy_q || (bus.start && w_multi && !bus.cancel);
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.div_zero  = dz_q;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
// Module      : tb_md_unit
// Description : Self-checking bench for md_unit: directed vector table,
//               hand-written multi-cycle sequences and randomized ops checked
//               against a behavioural model. Honours MD_MADD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_unit;
    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk;
    logic reset;
    md_if #(.WIDTH(W)) bus ();

    md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state
    logic [W-1:0] m_hi, m_lo;
    logic         m_dz;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a, b, e_hi, e_lo;
        logic         e_dz;
        int           e_cyc;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural reference: arithmetic straight from the operation rules.
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int cyc);
        longint       sa, sb;
        logic [63:0]  p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        cyc = 0;
        case (op)
            4'd0: begin p = 64'(sa * sb);                 {m_hi, m_lo} = p; cyc = MC; end
            4'd1: begin p = {32'd0, a} * {32'd0, b};      {m_hi, m_lo} = p; cyc = MC; end
            4'd2, 4'd3: begin
                cyc = DC;
                if (b == 0) begin
                    m_lo = '1; m_hi = a; m_dz = 1'b1;
                end else begin
                    m_dz = 1'b0;
                    if (op == 4'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        m_lo = a; m_hi = 0;
                    end else if (op == 4'd2) begin
                        m_lo = 32'(sa / sb); m_hi = 32'(sa % sb);
                    end else begin
                        m_lo = a / b; m_hi = a % b;
                    end
                end
            end
            4'd4: m_hi = a;
            4'd5: m_lo = a;
`ifdef MD_MADD_EN
            4'd6, 4'd8: begin
                p = 64'(sa * sb);
                {m_hi, m_lo} = (op == 4'd6) ? {m_hi, m_lo} + p : {m_hi, m_lo} - p;
                cyc = MC;
            end
            4'd7, 4'd9: begin
                p = {32'd0, a} * {32'd0, b};
                {m_hi, m_lo} = (op == 4'd7) ? {m_hi, m_lo} + p : {m_hi, m_lo} - p;
                cyc = MC;
            end
`endif
            default: cyc = 0;
        endcase
    endtask

    // Wait at negedges while busy, bounded; returns the busy cycle count.
    task automatic wait_idle(input string tag, input logic [W-1:0] ph, input logic [W-1:0] pl,
                             output int cyc, output bit held);
        cyc  = 0;
        held = 1'b1;
        while (bus.busy === 1'b1 && cyc < 500) begin
            if (bus.hi !== ph || bus.lo !== pl) held = 1'b0;
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 500) begin
            n_vec++; n_err++;
            $display("FAIL %s timeout: busy still %b after %0d cycles, required 0", tag, bus.busy, cyc);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] e_hi, input logic [W-1:0] e_lo, input logic e_dz,
                          input int e_cyc, input string tag);
        logic [W-1:0] ph, pl;
        int cyc;
        bit held;
        @(negedge clk);
        ph = bus.hi; pl = bus.lo;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        #1 chk({tag, " stall_req"}, 64'(bus.stall_req), 64'(e_cyc > 0));
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle(tag, ph, pl, cyc, held);
        chk({tag, " busy_cycles"}, 64'(cyc), 64'(e_cyc));
        if (e_cyc > 0) chk({tag, " hold"}, 64'(held), 64'd1);
        chk({tag, " hi"}, 64'(bus.hi), 64'(e_hi));
        chk({tag, " lo"}, 64'(bus.lo), 64'(e_lo));
        chk({tag, " div_zero"}, 64'(bus.div_zero), 64'(e_dz));
    endtask

    initial begin
        logic [W-1:0] ph, pl, ra, rb;
        logic [3:0]   rop;
        int           cyc, ecyc;
        bit           held;

        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
        reset = 1'b0;
        m_hi = '0; m_lo = '0; m_dz = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset hi", 64'(bus.hi), 64'd0);
        chk("reset lo", 64'(bus.lo), 64'd0);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset div_zero", 64'(bus.div_zero), 64'd0);
        chk("reset stall_req", 64'(bus.stall_req), 64'd0);
        reset = 1'b1;

        // ---------------- directed vector table ----------------
        vecs.push_back('{4'd0, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, MC});
        vecs.push_back('{4'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, DC});
        vecs.push_back('{4'd3, 32'hFFFF_FFF9, 32'd2,         32'd1,         32'h7FFF_FFFC, 1'b0, DC});
        vecs.push_back('{4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, DC});
        vecs.push_back('{4'd3, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, DC});
        vecs.push_back('{4'd1, 32'd2,         32'd3,         32'd0,         32'd6,         1'b1, MC});
        vecs.push_back('{4'd3, 32'd6,         32'd3,         32'd0,         32'd2,         1'b0, DC});
        vecs.push_back('{4'd4, 32'h1234,      32'd0,         32'h1234,      32'd2,         1'b0, 0});
        vecs.push_back('{4'd5, 32'h55,        32'd0,         32'h1234,      32'h55,        1'b0, 0});
        vecs.push_back('{4'd12, 32'hDEAD,     32'd7,         32'h1234,      32'h55,        1'b0, 0});
        vecs.push_back('{4'd4, 32'd0,         32'd0,         32'd0,         32'h55,        1'b0, 0});
        vecs.push_back('{4'd5, 32'hFFFF_FFFF, 32'd0,         32'd0,         32'hFFFF_FFFF, 1'b0, 0});
`ifdef MD_MADD_EN
        vecs.push_back('{4'd7, 32'd1,         32'd1,         32'd1,         32'd0,         1'b0, MC});
        vecs.push_back('{4'd8, 32'd1,         32'd2,         32'd0,         32'hFFFF_FFFE, 1'b0, MC});
`else
        vecs.push_back('{4'd7, 32'd1,         32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0, 0});
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e_hi, vecs[i].e_lo,
                   vecs[i].e_dz, vecs[i].e_cyc, $sformatf("vec%0d", i));
            m_hi = vecs[i].e_hi; m_lo = vecs[i].e_lo; m_dz = vecs[i].e_dz;
        end

        // ---------------- MTLO during busy is ignored; MTHI back-to-back ----------------
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'd1; bus.a = 32'd3; bus.b = 32'd4;
        @(negedge clk);
        bus.op = 4'd5; bus.a = 32'h55;
        #1 chk("mtlo_busy stall_req", 64'(bus.stall_req), 64'd1);
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle("mtlo_busy", bus.hi, bus.lo, cyc, held);
        chk("mtlo_busy hi", 64'(bus.hi), 64'd0);
        chk("mtlo_busy lo", 64'(bus.lo), 64'd12);
        bus.start = 1'b1; bus.op = 4'd4; bus.a = 32'hAA;
        #1 chk("mthi_b2b stall_req", 64'(bus.stall_req), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        chk("mthi_b2b busy", 64'(bus.busy), 64'd0);
        chk("mthi_b2b hi", 64'(bus.hi), 64'hAA);
        chk("mthi_b2b lo", 64'(bus.lo), 64'd12);
        m_hi = 32'hAA; m_lo = 32'd12;

        // ---------------- start with cancel is dropped ----------------
        bus.start = 1'b1; bus.cancel = 1'b1; bus.op = 4'd2; bus.a = 32'd9; bus.b = 32'd2;
        #1 chk("cancel_issue stall_req", 64'(bus.stall_req), 64'd0);
        @(negedge clk);
        bus.start = 1'b0; bus.cancel = 1'b0;
        chk("cancel_issue busy", 64'(bus.busy), 64'd0);
        chk("cancel_issue hilo", {bus.hi, bus.lo}, {m_hi, m_lo});

        // ---------------- cancel mid-MULT does not abort ----------------
        bus.start = 1'b1; bus.op = 4'd0; bus.a = 32'd7; bus.b = 32'hFFFF_FFFD;
        model(4'd0, 32'd7, 32'hFFFF_FFFD, ecyc);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        wait_idle("cancel_mid", bus.hi, bus.lo, cyc, held);
        chk("cancel_mid hi", 64'(bus.hi), 64'(m_hi));
        chk("cancel_mid lo", 64'(bus.lo), 64'(m_lo));

        // ---------------- reset mid-DIV ----------------
        bus.start = 1'b1; bus.op = 4'd2; bus.a = 32'd100; bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1 chk("reset_mid busy", 64'(bus.busy), 64'd0);
        chk("reset_mid hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        repeat (DC + 2) @(negedge clk);
        chk("reset_mid stays idle", {31'd0, bus.busy, bus.hi, bus.lo}, 64'd0);

        // ---------------- randomized ops against the model ----------------
        for (int i = 0; i < 80; i++) begin
            rop = 4'($urandom_range(0, 11));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            model(rop, ra, rb, ecyc);
            run_op(rop, ra, rb, m_hi, m_lo, m_dz, ecyc, $sformatf("rand%0d op%0d", i, rop));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers.
- Sits in the EX stage beside the ALU and is the successor of the fixed-latency 32-bit mult/div block.
- Adds configurable operand width and per-operation latency, divide-by-zero and overflow rules, exception-cancel of issue, and optional multiply-accumulate.
- Drives the pipeline stall request consumed by hazard logic.

Parameters:
- WIDTH, 32, operand and HI/LO width (>=8).
- MULT_CYCLES, 5, busy cycles for multiply-class ops (>=1).
- DIV_CYCLES, 10, busy cycles for divide-class ops (>=1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  issue strobe for op, sampled on clk rise.
- op  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU; 10-15 reserved.
- a  in  WIDTH  rs operand (dividend, multiplicand, or MTHI/MTLO data).
- b  in  WIDTH  rt operand (divisor or multiplier).
- cancel  in  1  exception/interrupt flush of the issuing instruction.
- busy  out  1  operation in flight.
- stall_req  out  1  combinational: busy OR (start AND op is multi-cycle AND !cancel).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- div_zero  out  1  sticky flag: last divide had b==0; cleared by the next accepted divide.

Behaviour:
- Reset (reset==0, asynchronous): hi=0, lo=0, busy=0, div_zero=0, counter=0, pending result=0.
- Accept: start && !cancel && !busy && op<=9. Any other start is ignored with no state change, including a start while busy, op>=10, or start && cancel in the same cycle.
- MTHI/MTLO accepted: hi or lo = a on the same edge. busy stays 0. Single cycle.
- Multi-cycle accept (MULT/MULTU/DIV/DIVU, plus MADD* / MSUB* when enabled):
  - Result is computed from a and b as sampled at accept.
  - Result is held in pending registers; counter loads N-1, where N = MULT_CYCLES or DIV_CYCLES.
  - busy=1 from the edge after accept for exactly N cycles.
  - On the edge where counter==0 while busy: hi/lo take the pending result and busy drops.
  - Result is visible on hi/lo in the first cycle busy==0.
- Multiply: full 2*WIDTH product. hi = upper half, lo = lower half. MULT is signed two's complement; MULTU is unsigned.
- Divide: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - Signed overflow (a = most-negative, b = -1): lo = a, hi = 0.
  - b==0: lo = all ones, hi = a, div_zero set. Full DIV_CYCLES latency still applies.
- cancel while busy does not abort. The in-flight op completes (it belongs to an older, committed instruction).
- hi/lo only change on accepted MT* or on completion. They are never partially updated.
- Counter width is $clog2 of the larger cycle parameter plus 1. No wrap-around is possible.
- Back-to-back issue: a start is accepted in the first cycle busy==0.
- Reset mid-operation discards the pending result and leaves hi=lo=0.

Optional Feature:
- Macro MD_MADD_EN.
- Defined: ops 6-9 are multi-cycle with MULT_CYCLES latency.
  - {hi,lo} = {hi,lo} +/- product. MADD/MSUB use a signed product; MADDU/MSUBU use unsigned. All arithmetic is modulo 2^(2*WIDTH).
  - The {hi,lo} used is the value at accept.
- Undefined: ops 6-9 are treated as reserved: ignored, stall_req=0, no state change.

Test Plan:
- MULT, a=0xFFFFFFFE (-2), b=3, defaults -> stall_req=1 in the issue cycle; busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIV, a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU with the same operands -> lo=0x7FFFFFFC, hi=1.
- DIV, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU, a=5, b=0 -> lo=0xFFFFFFFF, hi=5, div_zero=1; next DIVU 6/3 -> lo=2, hi=0, div_zero=0.
- MULTU 3*4 accepted, then MTLO a=0x55 issued during busy -> ignored; after completion lo=12, hi=0. MTHI a=0xAA in the next free cycle -> hi=0xAA with no busy.
- start=1, cancel=1, op=DIV -> no busy, stall_req=0, hi/lo unchanged. cancel pulsed mid-MULT -> MULT still completes. reset pulled low mid-DIV -> busy=0, hi=lo=0 immediately.
- MD_MADD_EN defined: hi=0, lo=0xFFFFFFFF, MADDU a=1, b=1 -> hi=1, lo=0. Then MSUB a=1, b=2 -> hi=0, lo=0xFFFFFFFE. Without the macro, the same op=7 -> ignored.
